// File: rtl/if_id_reg.sv
// if_id_reg: fetch/decode pipeline register with fetch-address check, bubble insertion and stall counter.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  input  logic        lock,
  input  logic        flush,
  input  logic        handle,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        bd_d,
  output logic [4:0]  exc_d,
  output logic        valid_d,
  output logic [7:0]  stall_cnt
);
  logic [31:0] id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic        id_bd_q, id_bd_d, id_valid_q, id_valid_d;
  logic [4:0]  id_exc_q, id_exc_d;
  logic [7:0]  id_cnt_q, id_cnt_d;
  logic        fault, kill, hold;
  assign fault = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);
  assign kill  = handle || flush;
  assign hold  = lock && !kill;
  always_comb begin
    id_pc_d    = handle ? EXC_PC : hold ? id_pc_q : pc_f;
    id_instr_d = kill ? 32'h0 : hold ? id_instr_q : fault ? 32'h0 : instr_f;
    id_bd_d    = kill ? 1'b0 : hold ? id_bd_q : bd_f;
    id_exc_d   = kill ? 5'd0 : hold ? id_exc_q : fault ? 5'd4 : 5'd0;
    id_valid_d = kill ? 1'b0 : hold ? id_valid_q : 1'b1;
    id_cnt_d   = !hold ? 8'd0 : (id_cnt_q == 8'd255) ? id_cnt_q : id_cnt_q + 8'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_pc_q    <= RESET_PC;
      id_instr_q <= 32'h0;
      id_bd_q    <= 1'b0;
      id_exc_q   <= 5'd0;
      id_valid_q <= 1'b0;
      id_cnt_q   <= 8'd0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_bd_q    <= id_bd_d;
      id_exc_q   <= id_exc_d;
      id_valid_q <= id_valid_d;
      id_cnt_q   <= id_cnt_d;
    end
  end
  assign pc_d      = id_pc_q;
  assign instr_d   = id_instr_q;
  assign bd_d      = id_bd_q;
  assign exc_d     = id_exc_q;
  assign valid_d   = id_valid_q;
  assign stall_cnt = id_cnt_q;
endmodule
